frame_buffer_reader: RTL and testbench

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

---
 rtl/frame_buffer_reader.sv | 103 ++++++++++
 tb/tb_frame_buffer_reader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: streams a frame from synchronous RAM into a 2-deep valid/ready pixel FIFO
module frame_buffer_reader #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  oe,
  output logic [ADDR_WIDTH-1:0] rAddr,
  input  logic [15:0]           rData,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           m_data,
  output logic [XW-1:0]         m_x,
  output logic [YW-1:0]         m_y,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int TW = XW + YW + 3;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(IMG_WIDTH*IMG_HEIGHT - 1);
  state_t state, state_nxt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic in_flight, pop, last_issue, eof_pop, wr_ptr, rd_ptr;
  logic [TW-1:0] tag_q;
  logic [TW+15:0] fifo_mem [2];
  logic [1:0] fifo_cnt;
  assign {m_eof, m_eol, m_sof, m_y, m_x, m_data} = fifo_mem[rd_ptr];
  // state register plus the registered completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= state == DRAIN && eof_pop;
    end
  end
  // next state: start launches a frame, last issue drains, eof handshake ends it
  always_comb begin
    state_nxt = state == IDLE ? (start ? READ : IDLE)
              : state == READ ? (last_issue ? DRAIN : READ)
              : (eof_pop ? IDLE : DRAIN);
  end
  // outputs: a read is issued only if the FIFO can still absorb it after this cycle's pop
  always_comb begin
    busy       = state != IDLE;
    m_valid    = fifo_cnt != 2'd0;
    pop        = m_valid & m_ready;
    oe         = state == READ && ({1'b0, fifo_cnt} + {2'b0, in_flight} - {2'b0, pop}) < 3'd2;
    last_issue = oe && rAddr == A_LAST;
    eof_pop    = pop && m_eof;
  end
  // issue side: address and pixel coordinates, tagged onto each read as it goes out
  always_ff @(posedge clk) begin
    if (reset) begin
      rAddr     <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      in_flight <= 1'b0;
      tag_q     <= '0;
    end else begin
      in_flight <= oe;
      if (state == IDLE && start) begin
        rAddr <= '0;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (oe) begin
        rAddr <= last_issue ? '0 : rAddr + ADDR_WIDTH'(1);
        x_cnt <= x_cnt == X_LAST ? '0 : x_cnt + XW'(1);
        y_cnt <= x_cnt == X_LAST ? (y_cnt == Y_LAST ? '0 : y_cnt + YW'(1)) : y_cnt;
        tag_q <= {last_issue, x_cnt == X_LAST, rAddr == '0, y_cnt, x_cnt};
      end
    end
  end
  // 2-entry pixel FIFO; returning data is dropped after reset because in_flight is cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (in_flight) begin
        fifo_mem[wr_ptr] <= {tag_q, rData};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: directed checks of a 4x3 frame reader against hand-derived expectations
module tb_frame_buffer_reader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, m_ready = 1'b0;
  logic busy, done, oe, m_valid, m_sof, m_eol, m_eof;
  logic [3:0] rAddr;
  logic [15:0] rData = '0, m_data;
  logic [1:0] m_x, m_y;
  int n_chk = 0, n_fail = 0;

  frame_buffer_reader #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .oe(oe),
    .rAddr(rAddr), .rData(rData), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_x(m_x), .m_y(m_y), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof));

  always #5 clk = ~clk;

  // synchronous RAM whose contents equal the address
  always @(posedge clk) if (oe) rData <= {12'h0, rAddr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_oe"}, oe, 0);
    chk({tag, "_raddr"}, rAddr, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_xy"}, {m_x, m_y}, 0);
    chk({tag, "_flags"}, {m_sof, m_eol, m_eof}, 0);
  endtask

  // mode 0: ready=1, mode 1: ready 1,0,1,0..., mode 2: ready=0 until cycle 10
  task automatic run_frame(input int mode, input bit hold, input bit spur);
    int p = 0, issued = 0;
    bit got_done = 0, prev_stall = 0;
    logic [15:0] prev_d = '0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(posedge clk); #2;
      start   = (c == 0) || hold || (spur && (c == 5 || c == 6));
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : (c > 10);
      #2;
      if (c == 0) chk("idle_busy", busy, 0);
      chk("oe_only_busy", oe && !busy, 0);
      if (oe) begin
        chk("raddr", rAddr, issued);
        issued++;
      end
      if (mode == 0) chk("valid_timing", m_valid, c >= 3 && c <= 14);
      if (m_valid) begin
        chk("data", m_data, p);
        chk("x", m_x, p % 4);
        chk("y", m_y, p / 4);
        chk("sof", m_sof, p == 0);
        chk("eol", m_eol, p % 4 == 3);
        chk("eof", m_eof, p == 11);
        if (prev_stall) chk("stall_stable", m_data, prev_d);
        if (m_ready) p++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      chk("outstanding", issued - p <= 2, 1);
      if (mode == 2 && c == 10) begin
        chk("bp_reads", issued, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 0);
      end
      if (done) begin
        got_done = 1;
        if (mode == 0) chk("done_cycle", c, 15);
        chk("done_busy", busy, 0);
        chk("done_pixels", p, 12);
      end
    end
    chk("got_done", got_done, 1);
  endtask

  initial begin
    bit seen5 = 0, first = 1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #2 check_zero("reset");
    run_frame(0, 0, 0);
    run_frame(1, 0, 0);
    run_frame(2, 0, 0);
    run_frame(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #4;
      chk("spur_no_done", done, 0);
      chk("spur_idle", busy, 0);
    end
    run_frame(0, 1, 0);
    @(posedge clk); #2;
    start = 1'b0;
    m_ready = 1'b1;
    #2;
    chk("b2b_busy", busy, 1);
    chk("b2b_oe", oe, 1);
    chk("b2b_raddr", rAddr, 0);
    for (int i = 0; i < 40 && !seen5; i++) begin
      @(posedge clk); #4;
      if (m_valid && m_ready) begin
        if (first) chk("b2b_first", m_data, 0);
        first = 0;
        if (m_data == 16'd5) seen5 = 1;
      end
    end
    chk("b2b_seen5", seen5, 1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    #2 check_zero("midreset");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #4;
      chk("midreset_no_done", done, 0);
      chk("midreset_valid", m_valid, 0);
    end
    run_frame(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
